// File: rtl/gemm_tile_scheduler.sv
// Tiles one GEMM job (M,K,N) into TileM x TileN output tiles and sequences the accelerator one tile at a time.
// Optional feature: define GEMM_TILE_SCHED_PERF_EN to add the perf_cycles_o busy-cycle counter.
module gemm_tile_scheduler #(
  parameter int SizeAddrWidth = 8,
  parameter int TileM         = 4,
  parameter int TileN         = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_start_i,
  input  logic                     abort_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic                     gemm_start_o,
  output logic [SizeAddrWidth-1:0] gemm_K_o,
  output logic [SizeAddrWidth-1:0] gemm_N_o,
  output logic [SizeAddrWidth-1:0] M_count_o,
  output logic [SizeAddrWidth-1:0] N_count_o,
  input  logic                     gemm_done_i,
  output logic                     busy_o,
  output logic                     done_o,
`ifdef GEMM_TILE_SCHED_PERF_EN
  output logic [31:0]              perf_cycles_o,
`endif
  output logic                     error_o
);

  localparam int MShift = $clog2(TileM);
  localparam int NShift = $clog2(TileN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SizeAddrWidth-1:0] m_q, k_q, n_q;
  logic [SizeAddrWidth-1:0] m_cnt_q, n_cnt_q;
  logic [SizeAddrWidth:0]   m_tiles, n_tiles;
  logic                     error_q;
  logic                     accept, reject, advance;
  logic                     last_n, last_tile;

  // One extra bit keeps ceil() exact for sizes near the top of the range.
  assign m_tiles = ({1'b0, m_q} + (SizeAddrWidth+1)'(TileM - 1)) >> MShift;
  assign n_tiles = ({1'b0, n_q} + (SizeAddrWidth+1)'(TileN - 1)) >> NShift;

  assign last_n    = ({1'b0, n_cnt_q} == n_tiles);
  assign last_tile = last_n && ({1'b0, m_cnt_q} == m_tiles);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          if ((M_size_i != '0) && (K_size_i != '0) && (N_size_i != '0)) begin
            accept  = 1'b1;
            state_d = ST_LAUNCH;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_LAUNCH: state_d = abort_i ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        // Abort wins over a coincident accelerator done.
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (gemm_done_i) begin
          if (last_tile) begin
            state_d = ST_DONE;
          end else begin
            advance = 1'b1;
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= reject;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      m_cnt_q <= SizeAddrWidth'(1);
      n_cnt_q <= SizeAddrWidth'(1);
    end else if (accept) begin
      m_q     <= M_size_i;
      k_q     <= K_size_i;
      n_q     <= N_size_i;
      m_cnt_q <= SizeAddrWidth'(1);
      n_cnt_q <= SizeAddrWidth'(1);
    end else if (advance) begin
      if (last_n) begin
        n_cnt_q <= SizeAddrWidth'(1);
        m_cnt_q <= m_cnt_q + SizeAddrWidth'(1);
      end else begin
        n_cnt_q <= n_cnt_q + SizeAddrWidth'(1);
      end
    end
  end

  assign gemm_start_o = (state_q == ST_LAUNCH);
  assign busy_o       = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  assign done_o       = (state_q == ST_DONE);
  assign error_o      = error_q;
  assign gemm_K_o     = k_q;
  assign gemm_N_o     = n_q;
  assign M_count_o    = m_cnt_q;
  assign N_count_o    = n_cnt_q;

`ifdef GEMM_TILE_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (busy_o) begin
      perf_q <= sat_inc(perf_q);
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler: tile ordering, rejection, abort, spurious inputs and reset.
// With GEMM_TILE_SCHED_PERF_EN defined it also exercises perf_cycles_o.
module tb_gemm_tile_scheduler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] m_size = '0, k_size = '0, n_size = '0;
  logic         gemm_start;
  logic [W-1:0] gemm_k, gemm_n, m_count, n_count;
  logic         gemm_done = 1'b0;
  logic         busy, done, error;
`ifdef GEMM_TILE_SCHED_PERF_EN
  logic [31:0]  perf_cycles;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] starts_q[$];
  int          done_seen = 0;
  int          err_seen = 0;

  always #5 clk = ~clk;

  gemm_tile_scheduler #(.SizeAddrWidth(W), .TileM(4), .TileN(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_start_i  (cfg_start),
    .abort_i      (abort),
    .M_size_i     (m_size),
    .K_size_i     (k_size),
    .N_size_i     (n_size),
    .gemm_start_o (gemm_start),
    .gemm_K_o     (gemm_k),
    .gemm_N_o     (gemm_n),
    .M_count_o    (m_count),
    .N_count_o    (n_count),
    .gemm_done_i  (gemm_done),
    .busy_o       (busy),
    .done_o       (done),
`ifdef GEMM_TILE_SCHED_PERF_EN
    .perf_cycles_o(perf_cycles),
`endif
    .error_o      (error)
  );

  // Record every start with its tile index, plus done/error pulses, mid-cycle.
  always @(negedge clk) begin
    if (gemm_start === 1'b1) starts_q.push_back({m_count, n_count});
    if (done === 1'b1) done_seen++;
    if (error === 1'b1) err_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_cfg(input logic [W-1:0] m, input logic [W-1:0] k, input logic [W-1:0] n);
    m_size = m; k_size = k; n_size = n;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Accelerator model: answers each start with a done pulse lat cycles later.
  task automatic serve(input int ntiles, input int lat, output int tmo);
    tmo = 0;
    for (int t = 0; t < ntiles; t++) begin
      int w = 0;
      while (gemm_start !== 1'b1 && w < 60) begin
        tick();
        w++;
      end
      if (w >= 60) begin
        tmo++;
        return;
      end
      repeat (lat) tick();
      gemm_done = 1'b1;
      tick();
      gemm_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if ({gemm_start, busy, done, error} !== 4'b0000) begin n_fail++; $display("FAIL reset_outs: got %b expected 0000", {gemm_start, busy, done, error}); end
    n_cmp++; if ({m_count, n_count} !== 16'h0101) begin n_fail++; $display("FAIL reset_counts: got %h expected 0101", {m_count, n_count}); end
    n_cmp++; if ({gemm_k, gemm_n} !== 16'h0000) begin n_fail++; $display("FAIL reset_sizes: got %h expected 0000", {gemm_k, gemm_n}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();
    n_cmp++; if ({gemm_start, busy, done, error} !== 4'b0000) begin n_fail++; $display("FAIL reset_release: got %b expected 0000", {gemm_start, busy, done, error}); end
  endtask

  task automatic test_job_8x12();
    logic [15:0] exp_t[6] = '{16'h0101, 16'h0102, 16'h0103, 16'h0201, 16'h0202, 16'h0203};
    int base = starts_q.size();
    int dbase;
    int tmo;
    dbase = done_seen;
    apply_cfg(8'd8, 8'd20, 8'd12);
    n_cmp++; if ({gemm_start, busy} !== 2'b11) begin n_fail++; $display("FAIL j8_first_start: got %b expected 11", {gemm_start, busy}); end
    n_cmp++; if ({gemm_k, gemm_n} !== {8'd20, 8'd12}) begin n_fail++; $display("FAIL j8_latched: got %0d/%0d expected 20/12", gemm_k, gemm_n); end
    // Inputs change mid-job; latched sizes must not follow.
    m_size = 8'd64; k_size = 8'd7; n_size = 8'd64;
    serve(6, 2, tmo);
    n_cmp++; if (tmo !== 0) begin n_fail++; $display("FAIL j8_timeout: got %0d expected 0", tmo); end
    n_cmp++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL j8_done: got done,busy=%b expected 10", {done, busy}); end
    n_cmp++; if ({gemm_k, gemm_n} !== {8'd20, 8'd12}) begin n_fail++; $display("FAIL j8_hold: got %0d/%0d expected 20/12", gemm_k, gemm_n); end
    tick(); tick();
    n_cmp++; if ({m_count, n_count} !== 16'h0203) begin n_fail++; $display("FAIL j8_final_counts: got %h expected 0203", {m_count, n_count}); end
    n_cmp++; if (starts_q.size() - base !== 6) begin n_fail++; $display("FAIL j8_nstarts: got %0d expected 6", starts_q.size() - base); end
    for (int i = 0; i < 6; i++) begin
      if (base + i < starts_q.size()) begin
        n_cmp++; if (starts_q[base+i] !== exp_t[i]) begin n_fail++; $display("FAIL j8_tile%0d: got %h expected %h", i, starts_q[base+i], exp_t[i]); end
      end
    end
    n_cmp++; if (done_seen - dbase !== 1) begin n_fail++; $display("FAIL j8_ndone: got %0d expected 1", done_seen - dbase); end
  endtask

  task automatic test_job_5x4();
    int base = starts_q.size();
    int dbase;
    int tmo;
    dbase = done_seen;
    apply_cfg(8'd5, 8'd3, 8'd4);
    serve(2, 1, tmo);
    n_cmp++; if (tmo !== 0) begin n_fail++; $display("FAIL j5_timeout: got %0d expected 0", tmo); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL j5_done: got %b expected 1", done); end
    tick(); tick();
    n_cmp++; if (starts_q.size() - base !== 2) begin n_fail++; $display("FAIL j5_nstarts: got %0d expected 2", starts_q.size() - base); end
    if (starts_q.size() - base >= 2) begin
      n_cmp++; if ({starts_q[base], starts_q[base+1]} !== 32'h0101_0201) begin n_fail++; $display("FAIL j5_tiles: got %h %h expected 0101 0201", starts_q[base], starts_q[base+1]); end
    end
    n_cmp++; if (done_seen - dbase !== 1) begin n_fail++; $display("FAIL j5_ndone: got %0d expected 1", done_seen - dbase); end
  endtask

  task automatic test_zero_size();
    int base = starts_q.size();
    int ebase;
    int tmo;
    ebase = err_seen;
    apply_cfg(8'd4, 8'd4, 8'd0);
    n_cmp++; if ({error, busy, gemm_start} !== 3'b100) begin n_fail++; $display("FAIL zero_err: got err,busy,start=%b expected 100", {error, busy, gemm_start}); end
    tick();
    n_cmp++; if ({error, busy} !== 2'b00) begin n_fail++; $display("FAIL zero_pulse: got err,busy=%b expected 00", {error, busy}); end
    tick(); tick();
    n_cmp++; if (err_seen - ebase !== 1) begin n_fail++; $display("FAIL zero_nerr: got %0d expected 1", err_seen - ebase); end
    n_cmp++; if (starts_q.size() - base !== 0) begin n_fail++; $display("FAIL zero_nstarts: got %0d expected 0", starts_q.size() - base); end
    apply_cfg(8'd4, 8'd4, 8'd4);
    serve(1, 3, tmo);
    n_cmp++; if ({tmo[0], done} !== 2'b01) begin n_fail++; $display("FAIL zero_followup: got tmo=%0d done=%b expected 0/1", tmo, done); end
    tick();
  endtask

  task automatic test_abort();
    int base = starts_q.size();
    int dbase;
    int tmo;
    dbase = done_seen;
    apply_cfg(8'd8, 8'd20, 8'd12);
    serve(1, 2, tmo);
    n_cmp++; if ({gemm_start, m_count, n_count} !== {1'b1, 16'h0102}) begin n_fail++; $display("FAIL ab_launch12: got start=%b tile=%h expected 1/0102", gemm_start, {m_count, n_count}); end
    tick();
    abort = 1'b1; gemm_done = 1'b1;
    tick();
    abort = 1'b0; gemm_done = 1'b0;
    n_cmp++; if ({busy, done, gemm_start} !== 3'b000) begin n_fail++; $display("FAIL ab_idle: got busy,done,start=%b expected 000", {busy, done, gemm_start}); end
    repeat (8) tick();
    n_cmp++; if (starts_q.size() - base !== 2) begin n_fail++; $display("FAIL ab_nstarts: got %0d expected 2", starts_q.size() - base); end
    n_cmp++; if (done_seen - dbase !== 0) begin n_fail++; $display("FAIL ab_ndone: got %0d expected 0", done_seen - dbase); end
  endtask

  task automatic test_spurious();
    int base = starts_q.size();
    int dbase;
    int tmo;
    dbase = done_seen;
    gemm_done = 1'b1; abort = 1'b1;
    tick();
    gemm_done = 1'b0; abort = 1'b0;
    tick();
    n_cmp++; if ({busy, gemm_start, done} !== 3'b000) begin n_fail++; $display("FAIL sp_idle: got busy,start,done=%b expected 000", {busy, gemm_start, done}); end
    apply_cfg(8'd5, 8'd3, 8'd4);
    tick();
    // New request while busy must not disturb the running job.
    m_size = 8'd16; k_size = 8'd9; n_size = 8'd16; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    gemm_done = 1'b1;
    tick();
    gemm_done = 1'b0;
    serve(1, 1, tmo);
    n_cmp++; if ({tmo[0], done} !== 2'b01) begin n_fail++; $display("FAIL sp_done: got tmo=%0d done=%b expected 0/1", tmo, done); end
    n_cmp++; if ({gemm_k, gemm_n} !== {8'd3, 8'd4}) begin n_fail++; $display("FAIL sp_latched: got %0d/%0d expected 3/4", gemm_k, gemm_n); end
    tick(); tick();
    n_cmp++; if (starts_q.size() - base !== 2) begin n_fail++; $display("FAIL sp_nstarts: got %0d expected 2", starts_q.size() - base); end
    if (starts_q.size() - base >= 2) begin
      n_cmp++; if ({starts_q[base], starts_q[base+1]} !== 32'h0101_0201) begin n_fail++; $display("FAIL sp_tiles: got %h %h expected 0101 0201", starts_q[base], starts_q[base+1]); end
    end
    n_cmp++; if (done_seen - dbase !== 1) begin n_fail++; $display("FAIL sp_ndone: got %0d expected 1", done_seen - dbase); end
  endtask

  task automatic test_reset_mid_job();
    int base = starts_q.size();
    int dbase, ebase;
    int tmo;
    dbase = done_seen;
    ebase = err_seen;
    apply_cfg(8'd8, 8'd20, 8'd12);
    serve(1, 1, tmo);
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, gemm_start, done, error} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_outs: got %b expected 0000", {busy, gemm_start, done, error}); end
    n_cmp++; if ({m_count, n_count, gemm_k, gemm_n} !== 32'h0101_0000) begin n_fail++; $display("FAIL rst_mid_regs: got %h expected 01010000", {m_count, n_count, gemm_k, gemm_n}); end
`ifdef GEMM_TILE_SCHED_PERF_EN
    n_cmp++; if (perf_cycles !== 32'd0) begin n_fail++; $display("FAIL rst_mid_perf: got %0d expected 0", perf_cycles); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) tick();
    n_cmp++; if (starts_q.size() - base !== 2) begin n_fail++; $display("FAIL rst_mid_nstarts: got %0d expected 2", starts_q.size() - base); end
    n_cmp++; if ({done_seen - dbase, err_seen - ebase} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL rst_mid_pulses: got done=%0d err=%0d expected 0/0", done_seen - dbase, err_seen - ebase); end
  endtask

`ifdef GEMM_TILE_SCHED_PERF_EN
  task automatic test_perf();
    int tmo;
    apply_cfg(8'd4, 8'd4, 8'd4);
    // Accelerator registers start at the end of the launch cycle and answers 10 cycles later.
    serve(1, 11, tmo);
    n_cmp++; if ({tmo[0], done} !== 2'b01) begin n_fail++; $display("FAIL perf_done: got tmo=%0d done=%b expected 0/1", tmo, done); end
    n_cmp++; if (perf_cycles !== 32'd12) begin n_fail++; $display("FAIL perf_count: got %0d expected 12", perf_cycles); end
    repeat (3) tick();
    n_cmp++; if (perf_cycles !== 32'd12) begin n_fail++; $display("FAIL perf_hold: got %0d expected 12", perf_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_job_8x12();
    test_job_5x4();
    test_zero_size();
    test_abort();
    test_spurious();
`ifdef GEMM_TILE_SCHED_PERF_EN
    test_perf();
`endif
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
